// File: rtl/linebuffer_fill_ctrl_if.sv
// rtl/linebuffer_fill_ctrl_if.sv - fetch, line-buffer fill and instruction-memory signals of the refill sequencer
interface linebuffer_fill_ctrl_if;
    logic         req_valid;
    logic [31:0]  req_pc;
    logic         lb_hit;
    logic         flush;
    logic         fill_valid;
    logic [31:0]  fill_addr;
    logic [255:0] fill_data;
    logic         invalidate;
    logic         mem_read;
    logic [31:0]  mem_addr;
    logic         mem_ready;
    logic         mem_rvalid;
    logic [63:0]  mem_rdata;
    logic         busy;

    modport master (
        input  req_valid, req_pc, lb_hit, flush, mem_ready, mem_rvalid, mem_rdata,
        output fill_valid, fill_addr, fill_data, invalidate, mem_read, mem_addr, busy
    );

    modport slave (
        output req_valid, req_pc, lb_hit, flush, mem_ready, mem_rvalid, mem_rdata,
        input  fill_valid, fill_addr, fill_data, invalidate, mem_read, mem_addr, busy
    );
endinterface

// File: rtl/linebuffer_fill_ctrl.sv
// rtl/linebuffer_fill_ctrl.sv - line-buffer miss/refill sequencer: one 4-beat line read, drained one word per cycle
module linebuffer_fill_ctrl (
    input  logic                   clk,
    input  logic                   rst_n,
    linebuffer_fill_ctrl_if.master bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RECV = 2'd2
    } state_t;

    state_t      state, state_nxt;
    logic [26:0] line_tag;
    logic [63:0] beat_buf [4];
    logic [2:0]  bcnt, bcnt_nxt;
    logic [3:0]  widx, widx_nxt;
    logic        discard, discard_nxt;
    logic        miss, beat_take, fill_fire;
    logic [31:0] fill_word;

    assign miss      = bus.req_valid && !bus.lb_hit && !bus.flush;
    assign beat_take = (state == RECV) && bus.mem_rvalid && (bcnt != 3'd4);
    // Drain only words whose beat is already registered; a beat landing now waits a cycle.
    assign fill_fire = (state == RECV) && !discard && !bus.flush && (widx < {bcnt, 1'b0});

    assign bcnt_nxt    = bcnt + {2'b00, beat_take};
    assign widx_nxt    = widx + {3'b000, fill_fire};
    assign discard_nxt = discard || ((state != IDLE) && bus.flush);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Completion looks at the post-update counts so busy drops right after the last word or beat.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (miss) state_nxt = REQ;
            REQ:  if (bus.mem_ready) state_nxt = RECV;
            RECV: if ((bcnt_nxt == 3'd4) && (discard_nxt || (widx_nxt == 4'd8))) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.mem_read   = (state == REQ);
        bus.busy       = (state != IDLE);
        bus.mem_addr   = {line_tag, 5'b0};
        bus.invalidate = bus.flush;
        bus.fill_valid = fill_fire;
        bus.fill_addr  = {line_tag, widx[2:0], 2'b00};
        fill_word      = widx[0] ? beat_buf[widx[2:1]][63:32] : beat_buf[widx[2:1]][31:0];
        bus.fill_data  = '0;
        bus.fill_data[{widx[2:0], 5'd0} +: 32] = fill_word;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            line_tag <= '0;
            bcnt     <= '0;
            widx     <= '0;
            discard  <= 1'b0;
            for (int i = 0; i < 4; i++) beat_buf[i] <= '0;
        end else if (state == IDLE) begin
            if (miss) begin
                line_tag <= bus.req_pc[31:5];
                bcnt     <= '0;
                widx     <= '0;
                discard  <= 1'b0;
            end
        end else begin
            bcnt    <= bcnt_nxt;
            widx    <= widx_nxt;
            discard <= discard_nxt;
            if (beat_take) beat_buf[bcnt[1:0]] <= bus.mem_rdata;
        end
    end
endmodule

// File: tb/tb_linebuffer_fill_ctrl.sv
// tb/tb_linebuffer_fill_ctrl.sv - randomized bench for linebuffer_fill_ctrl against a transaction-level model
module tb_linebuffer_fill_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    linebuffer_fill_ctrl_if bus();
    linebuffer_fill_ctrl dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    logic         s_mem_read, s_busy, s_fill_valid;
    logic [31:0]  s_mem_addr, s_fill_addr;
    logic [255:0] s_fill_data;

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h cycle=%0d", tag, got, exp, cyc);
        end
    endtask

    task automatic step();
        @(negedge clk);
        s_mem_read   = bus.mem_read;
        s_busy       = bus.busy;
        s_mem_addr   = bus.mem_addr;
        s_fill_valid = bus.fill_valid;
        s_fill_addr  = bus.fill_addr;
        s_fill_data  = bus.fill_data;
        chk("invalidate", 256'(bus.invalidate), 256'(bus.flush));
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle_cycle(input bit hit_only);
        bit fl;
        fl = !hit_only && ($urandom_range(0, 5) == 0);
        bus.req_valid  = hit_only ? 1'b1 : 1'($urandom_range(0, 1));
        bus.req_pc     = $urandom;
        bus.lb_hit     = fl ? 1'b0 : 1'b1;
        bus.flush      = fl;
        bus.mem_ready  = hit_only ? 1'b0 : 1'($urandom_range(0, 1));
        bus.mem_rvalid = hit_only ? 1'b0 : 1'($urandom_range(0, 1));
        bus.mem_rdata  = {$urandom, $urandom};
        step();
        chk("idle_busy", 256'(s_busy), 256'(0));
        chk("idle_mem_read", 256'(s_mem_read), 256'(0));
        chk("idle_fill_valid", 256'(s_fill_valid), 256'(0));
    endtask

    // fmode: 0 none, 1 flush in REQ, 2 flush in RECV; foff < 0 picks a random point.
    task automatic run_txn(input logic [31:0] pc, input int acc_dly, input int gap, input bit dir,
                           input int fmode, input int foff);
        int T[4];
        int fc[8];
        logic [63:0] beat[4];
        int c0, a_cyc, fcy, drop_exp, nexp, nchk;
        logic [31:0] w;
        int got_cyc[$];
        logic [31:0] got_addr[$];
        logic [255:0] got_data[$];

        c0    = cyc;
        a_cyc = c0 + 1 + acc_dly;
        for (int k = 0; k < 4; k++) begin
            T[k] = ((k == 0) ? a_cyc + 1 : T[k-1] + 1) + ((gap < 0) ? int'($urandom_range(0, 3)) : gap);
            beat[k] = dir ? {32'h101 + 32'(2*k), 32'h100 + 32'(2*k)} : {$urandom, $urandom};
        end
        fc[0] = T[0] + 1;
        for (int i = 1; i < 8; i++)
            fc[i] = (T[i/2] + 1 > fc[i-1] + 1) ? T[i/2] + 1 : fc[i-1] + 1;

        fcy = -1;
        if (fmode == 1) fcy = c0 + 1 + ((foff < 0) ? int'($urandom_range(0, acc_dly)) : foff);
        if (fmode == 2) fcy = (foff < 0) ? a_cyc + 1 + int'($urandom_range(0, fc[7] - a_cyc - 1)) : T[0] + foff;

        drop_exp = (fcy < 0) ? fc[7] + 1 : ((fcy > T[3]) ? fcy : T[3]) + 1;
        nexp = 0;
        for (int i = 0; i < 8; i++) if (fcy < 0 || fc[i] < fcy) nexp++;

        for (int t = c0; t <= drop_exp; t++) begin
            bus.req_valid  = (t == c0) ? 1'b1 : ((t <= T[3]) ? 1'($urandom_range(0, 1)) : 1'b0);
            bus.lb_hit     = (t == c0) ? 1'b0 : 1'($urandom_range(0, 1));
            bus.req_pc     = (t == c0) ? pc : $urandom;
            bus.flush      = (t == fcy);
            bus.mem_ready  = (t == a_cyc);
            bus.mem_rvalid = 1'b0;
            bus.mem_rdata  = {$urandom, $urandom};
            if (t > c0 && t <= a_cyc) bus.mem_rvalid = 1'($urandom_range(0, 1));
            for (int k = 0; k < 4; k++) begin
                if (t == T[k]) begin
                    bus.mem_rvalid = 1'b1;
                    bus.mem_rdata  = beat[k];
                end
            end
            step();
            chk("busy", 256'(s_busy), 256'(t > c0 && t < drop_exp));
            chk("mem_read", 256'(s_mem_read), 256'(t > c0 && t <= a_cyc));
            if (t > c0 && t <= a_cyc) chk("mem_addr", 256'(s_mem_addr), 256'({pc[31:5], 5'b0}));
            if (s_fill_valid) begin
                got_cyc.push_back(t);
                got_addr.push_back(s_fill_addr);
                got_data.push_back(s_fill_data);
            end
        end

        chk("fill_count", 256'(got_cyc.size()), 256'(nexp));
        nchk = (got_cyc.size() < nexp) ? got_cyc.size() : nexp;
        for (int j = 0; j < nchk; j++) begin
            w = (j % 2 == 1) ? beat[j/2][63:32] : beat[j/2][31:0];
            chk("fill_cycle", 256'(got_cyc[j]), 256'(fc[j]));
            chk("fill_addr", 256'(got_addr[j]), 256'({pc[31:5], 3'(j), 2'b00}));
            chk("fill_data", got_data[j], 256'(w) << (32 * j));
        end
    endtask

    initial begin
        bus.req_valid  = 1'b0;
        bus.req_pc     = '0;
        bus.lb_hit     = 1'b0;
        bus.flush      = 1'b0;
        bus.mem_ready  = 1'b0;
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata  = '0;
        #1 rst_n = 1'b0;
        #1;
        chk("rst_mem_read", 256'(bus.mem_read), 256'(0));
        chk("rst_busy", 256'(bus.busy), 256'(0));
        chk("rst_fill_valid", 256'(bus.fill_valid), 256'(0));
        chk("rst_fill_addr", 256'(bus.fill_addr), 256'(0));
        chk("rst_fill_data", bus.fill_data, 256'(0));
        chk("rst_mem_addr", 256'(bus.mem_addr), 256'(0));
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++) idle_cycle(1'b1);

        run_txn(32'h0000_1234, 1, 0, 1'b1, 0, 0);
        idle_cycle(1'b0);
        run_txn(32'h0000_4560, 0, 2, 1'b0, 0, 0);
        idle_cycle(1'b0);
        run_txn(32'h0000_7780, 3, 0, 1'b0, 1, 0);
        idle_cycle(1'b0);
        run_txn(32'h0000_9900, 0, 2, 1'b0, 2, 5);
        run_txn(32'h0000_aa40, 1, 0, 1'b0, 0, 0);

        // Reset in the middle of a fill, right after beat 1.
        bus.req_valid = 1'b1; bus.lb_hit = 1'b0; bus.req_pc = 32'hdead_beef;
        bus.flush = 1'b0; bus.mem_ready = 1'b0; bus.mem_rvalid = 1'b0;
        step();
        bus.req_valid = 1'b0; bus.mem_ready = 1'b1;
        step();
        bus.mem_ready = 1'b0; bus.mem_rvalid = 1'b1; bus.mem_rdata = 64'h1111_1111_0000_0000;
        step();
        bus.mem_rdata = 64'h3333_3333_2222_2222;
        step();
        bus.mem_rvalid = 1'b0;
        #1;
        chk("pre_rst_fill_valid", 256'(bus.fill_valid), 256'(1));
        rst_n = 1'b0;
        bus.flush = 1'b1;
        #1;
        chk("mid_rst_mem_read", 256'(bus.mem_read), 256'(0));
        chk("mid_rst_busy", 256'(bus.busy), 256'(0));
        chk("mid_rst_fill_valid", 256'(bus.fill_valid), 256'(0));
        chk("mid_rst_fill_addr", 256'(bus.fill_addr), 256'(0));
        chk("mid_rst_fill_data", bus.fill_data, 256'(0));
        chk("mid_rst_mem_addr", 256'(bus.mem_addr), 256'(0));
        chk("mid_rst_invalidate", 256'(bus.invalidate), 256'(1));
        bus.flush = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        run_txn(32'h0001_0020, 2, -1, 1'b0, 0, 0);

        for (int n = 0; n < 40; n++) begin
            int r, idl;
            r = $urandom_range(0, 9);
            idl = $urandom_range(0, 3);
            for (int i = 0; i < idl; i++) idle_cycle(1'b0);
            run_txn($urandom, $urandom_range(0, 3), -1, 1'b0, (r < 6) ? 0 : ((r < 8) ? 1 : 2), -1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
